// File: rtl/freq_pkg.sv
// Shared constants and helpers for the frequency-counter display path.
package freq_pkg;

    localparam int BCD_W = 4;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Per-digit dwell in clock cycles, never below one.
    function automatic int calc_div(input int clk_hz, input int refresh_hz, input int num_digits);
        int d;
        d = clk_hz / (refresh_hz * num_digits);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/freq_display_mux_if.sv
// Digit/strobe inputs and 7-segment pins of the display mux; FREQ_DISP_OVF_EN adds overflow.
interface freq_display_mux_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic                    load;
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   an;
`ifdef FREQ_DISP_OVF_EN
    logic                    overflow;

    modport master (output digits_in, load, overflow, input seg, an);
    modport slave  (input digits_in, load, overflow, output seg, an);
`else
    modport master (output digits_in, load, input seg, an);
    modport slave  (input digits_in, load, output seg, an);
`endif
endinterface

// File: rtl/freq_display_mux_bcd_to_7seg.sv
// Combinational BCD nibble to active-high {g,f,e,d,c,b,a} code; non-BCD shows a dash.
module bcd_to_7seg
    import freq_pkg::*;
(
    input  logic [BCD_W-1:0] nibble,
    input  logic             blank,
    output logic [6:0]       code
);

    always_comb begin
        // NOTE: default first so every path assigns code and no latch is inferred.
        code = SEG_DASH;
        if (blank) begin
            code = SEG_BLANK;
        end else begin
            case (nibble)
                4'd0:    code = SEG_0;
                4'd1:    code = SEG_1;
                4'd2:    code = SEG_2;
                4'd3:    code = SEG_3;
                4'd4:    code = SEG_4;
                4'd5:    code = SEG_5;
                4'd6:    code = SEG_6;
                4'd7:    code = SEG_7;
                4'd8:    code = SEG_8;
                4'd9:    code = SEG_9;
                default: code = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/freq_display_mux.sv
// Captures BCD digits on load and scans them onto a multiplexed 7-segment display.
// Optional overflow-dash feature enabled by defining FREQ_DISP_OVF_EN.
module freq_display_mux
    import freq_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_HZ     = 100000000,
    parameter int REFRESH_HZ = 1000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic             clk,
    input  logic             reset,
    freq_display_mux_if.slave bus
);

    localparam int DIV = calc_div(CLK_HZ, REFRESH_HZ, NUM_DIGITS);
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam bit INV = (ACTIVE_LOW != 0);
    localparam logic [6:0]            SEG_OFF = INV ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = INV ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [PW-1:0]               prescaler;
    logic [IW-1:0]               index;
    logic [BCD_W*NUM_DIGITS-1:0] shadow;
    logic                        tick;
    logic [NUM_DIGITS-1:0]       blank_vec;
    logic [NUM_DIGITS-1:0]       an_hot;
    logic [BCD_W-1:0]            nibble;
    logic                        blank;
    logic [6:0]                  code;
    logic [6:0]                  seg_q;
    logic [NUM_DIGITS-1:0]       an_q;

    assign tick = (prescaler == PW'(DIV - 1));

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (reset) begin
            prescaler <= '0;
            index     <= '0;
            shadow    <= '0;
        end else begin
            prescaler <= tick ? '0 : prescaler + PW'(1);
            if (tick)
                index <= (index == IW'(NUM_DIGITS - 1)) ? '0 : index + IW'(1);
            if (bus.load)
                shadow <= bus.digits_in;
        end
    end

    // Scan from the top digit down: a digit blanks while nothing above or at it is non-zero.
    always_comb begin
        logic seen;
        seen      = 1'b0;
        blank_vec = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            seen         = seen | (shadow[k*BCD_W +: BCD_W] != '0);
            blank_vec[k] = !seen && (k != 0);
        end
    end

    always_comb begin
        an_hot        = '0;
        an_hot[index] = 1'b1;
    end

`ifdef FREQ_DISP_OVF_EN
    logic ovf_reg;

    always_ff @(posedge clk) begin
        if (reset)
            ovf_reg <= 1'b0;
        else if (bus.load)
            ovf_reg <= bus.overflow;
    end

    assign nibble = ovf_reg ? 4'hF : shadow[int'(index)*BCD_W +: BCD_W];
    assign blank  = ovf_reg ? 1'b0 : blank_vec[index];
`else
    assign nibble = shadow[int'(index)*BCD_W +: BCD_W];
    assign blank  = blank_vec[index];
`endif

    bcd_to_7seg u_bcd_to_7seg (
        .nibble (nibble),
        .blank  (blank),
        .code   (code)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q <= SEG_OFF;
            an_q  <= AN_OFF;
        end else begin
            seg_q <= INV ? ~code : code;
            an_q  <= INV ? ~an_hot : an_hot;
        end
    end

    assign bus.seg = seg_q;
    assign bus.an  = an_q;

endmodule

// File: tb/tb_freq_display_mux.sv
// Randomized self-checking bench for freq_display_mux against a frame-level reference model.
module tb_freq_display_mux;

    localparam int N          = 4;
    localparam int CLK_HZ     = 8000;
    localparam int REFRESH_HZ = 500;
    localparam int DIV        = CLK_HZ / (REFRESH_HZ * N);

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference state: captured value and edges elapsed since reset was released.
    logic [15:0] m_shadow;
    int          m_t;
    logic [6:0]  exp_seg;
    logic [3:0]  exp_an;

    int seg_tab [16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                         'h7F, 'h6F, 'h40, 'h40, 'h40, 'h40, 'h40, 'h40};

    freq_display_mux_if #(.NUM_DIGITS(N)) bus ();

    freq_display_mux #(
        .NUM_DIGITS (N),
        .CLK_HZ     (CLK_HZ),
        .REFRESH_HZ (REFRESH_HZ),
        .ACTIVE_LOW (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int cur_index();
        return (m_t / DIV) % N;
    endfunction

    // Active-low pattern for digit k of a value, from the display rules directly.
    function automatic logic [6:0] model_seg(input logic [15:0] value, input int k);
        logic [15:0] upper;
        int          code;
        upper = value >> (4 * k);
        if (k != 0 && upper == 16'h0)
            code = 0;
        else
            code = seg_tab[upper[3:0]];
        return ~7'(code);
    endfunction

    // One clock: apply inputs, advance the model across the edge, compare pins after it.
    task automatic step(input logic rst, input logic ld, input logic [15:0] d);
        reset         = rst;
        bus.load      = ld;
        bus.digits_in = d;
        if (rst) begin
            exp_seg = 7'h7F;
            exp_an  = 4'hF;
        end else begin
            exp_seg = model_seg(m_shadow, cur_index());
            exp_an  = ~(4'b0001 << cur_index());
        end
        @(posedge clk);
        if (rst) begin
            m_shadow = 16'h0;
            m_t      = 0;
        end else begin
            if (ld)
                m_shadow = d;
            m_t++;
        end
        #1;
        check("an", 32'(bus.an), 32'(exp_an));
        check("seg", 32'(bus.seg), 32'(exp_seg));
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++)
            step(1'b0, 1'b0, 16'h0);
    endtask

    initial begin
        logic [15:0] d;
        reset         = 1'b1;
        bus.load      = 1'b0;
        bus.digits_in = '0;
`ifdef FREQ_DISP_OVF_EN
        bus.overflow  = 1'b0;
`endif
        m_shadow = 16'h0;
        m_t      = 0;

        // Reset held three cycles, with a load that must be ignored.
        step(1'b1, 1'b0, 16'h0);
        step(1'b1, 1'b1, 16'h8765);
        step(1'b1, 1'b0, 16'h0);
        check("rst_seg", 32'(bus.seg), 32'h7F);
        check("rst_an", 32'(bus.an), 32'hF);

        step(1'b0, 1'b0, 16'h0);
        check("first_an", 32'(bus.an), 32'hE);
        check("first_seg", 32'(bus.seg), 32'h40);
        idle(4 * DIV + 2);

        // Directed values from the display rules.
        step(1'b0, 1'b1, 16'h1234);
        idle(2 * N * DIV);
        step(1'b0, 1'b1, 16'h0050);
        idle(2 * N * DIV);
        step(1'b0, 1'b1, 16'h00A0);
        idle(2 * N * DIV);

        // Load landing on the same edge as the scan tick.
        step(1'b0, 1'b1, 16'h9999);
        while ((m_t % DIV) != DIV - 1)
            step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b1, 16'h0001);
        idle(N * DIV);

        // Reset mid-frame while digit 2 is being shown.
        step(1'b0, 1'b1, 16'h4321);
        while (cur_index() != 2)
            step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 16'h0);
        check("midrst_pre_an", 32'(bus.an), 32'hB);
        step(1'b1, 1'b0, 16'h0);
        check("midrst_an", 32'(bus.an), 32'hF);
        check("midrst_seg", 32'(bus.seg), 32'h7F);
        step(1'b0, 1'b0, 16'h0);
        check("restart_an", 32'(bus.an), 32'hE);
        check("restart_seg", 32'(bus.seg), 32'h40);
        idle(N * DIV);

        // Random phase: sparse loads with leading zeros and non-BCD nibbles, rare resets.
        for (int i = 0; i < 3000; i++) begin
            d = 16'($urandom);
            if ($urandom_range(0, 1) == 0)
                d = d & 16'h7777;
            d = d >> (4 * $urandom_range(0, 4));
            step($urandom_range(0, 299) == 0, $urandom_range(0, 11) == 0, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
